uart_rx: RTL and testbench

Serial receiver for the 8N1 UART link. It recovers bytes from the asynchronous RX line, framed as 1 start bit, 8 data bits LSB first, and 1 stop bit. It presents each byte with a sticky ready flag for the command-processing logic, and flags framing and overrun errors. It is the line-side peer of the UART transmitter and is bench-tested in loopback against it: transmitter TX drives this block's RX.

---
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop RX synchronizer, mid-bit sampling driven by a
// baud down-counter, sticky ready / framing-error / overrun flags.
module uart_rx #(
  parameter int BAUD_DIV = 5208,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(HALF_DIV);
  localparam logic [CNT_W-1:0] BAUD_LD = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, RECV, WAIT_IDLE} state_t;

  logic             rx_meta_q, rx_s_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rdy_q, rdy_d;
  logic             frm_q, frm_d;
  logic             ovr_q, ovr_d;

  // Synchronize RX into the clk domain; preset high so reset looks like idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Control state and output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      rx_data_q <= 8'h00;
      rdy_q     <= 1'b0;
      frm_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
      frm_q     <= frm_d;
      ovr_q     <= ovr_d;
    end
  end

  // Data shift register; only consumed after a full frame, so no reset needed.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // Next-state: start detect, sample strobes, stop-bit handling, flag updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    rdy_d     = rdy_q;
    frm_d     = frm_q;
    ovr_d     = ovr_q;

    // Consumer clear; a same-cycle set below overrides it.
    if (clr_rdy) begin
      rdy_d = 1'b0;
      frm_d = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          cnt_d     = HALF_LD;
          bit_cnt_d = 4'd0;
          state_d   = RECV;
        end
      end
      RECV: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d     = BAUD_LD;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0) begin
            // Start bit no longer low at mid-bit: treat as a glitch.
            if (rx_s_q) state_d = IDLE;
          end else if (bit_cnt_q < 4'd9) begin
            shift_d = {rx_s_q, shift_q[7:1]};
          end else if (rx_s_q) begin
            rx_data_d = shift_q;
            rdy_d     = 1'b1;
            if (rdy_q && !clr_rdy) ovr_d = 1'b1;
            state_d   = IDLE;
          end else begin
            frm_d   = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Hold off through a break until the line returns high.
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_q;
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized/directed bench for uart_rx with a frame-level behavioural model.
module tb_uart_rx;

  localparam int B = 32;
  localparam int H = 16;
  localparam int LAT_NOM = 2 + H + 9 * B + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy, frm_err, ovr;

  uart_rx #(.BAUD_DIV(B), .HALF_DIV(H)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rdy(clr_rdy),
    .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err), .ovr(ovr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level reference model
  logic [7:0] m_data;
  logic       m_rdy, m_frm, m_ovr;

  // Latency monitor: cycles from RX falling edge of a frame to rdy rising
  int   cyc = 0;
  int   t_fall = 0;
  int   lat = -1;
  logic lat_arm = 1'b0;
  logic rdy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdy && !rdy_prev && lat_arm) begin
      lat     <= cyc - t_fall;
      lat_arm <= 1'b0;
    end
    rdy_prev <= rdy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rdy"},     32'(rdy),     32'(m_rdy));
    check({tag, ".rx_data"}, 32'(rx_data), 32'(m_data));
    check({tag, ".frm_err"}, 32'(frm_err), 32'(m_frm));
    check({tag, ".ovr"},     32'(ovr),     32'(m_ovr));
  endtask

  task automatic model_clear();
    m_rdy = 1'b0;
    m_frm = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_data = 8'h00;
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    model_clear();
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  // Drive one frame with bit period per; optionally pulse clr_rdy at the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int per,
                            input logic clr_first);
    RX = 1'b0;
    t_fall  = cyc;
    lat_arm = 1'b1;
    if (clr_first) begin
      clr_rdy = 1'b1;
      model_clear();
    end
    @(negedge clk);
    clr_rdy = 1'b0;
    repeat (per - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (per) @(negedge clk);
    end
    RX = stop;
    repeat (per) @(negedge clk);
    if (stop) begin
      if (m_rdy) m_ovr = 1'b1;
      m_rdy  = 1'b1;
      m_data = d;
    end else begin
      m_frm = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       stp, clr;
    int         per, got_lat;

    rst_n = 1'b0; RX = 1'b1; clr_rdy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    idle(2 * B);

    // Single byte with latency window and clear
    send_frame(8'hA5, 1'b1, B, 1'b0);
    check_all("a5");
    got_lat = (lat >= LAT_NOM - 10 && lat <= LAT_NOM + 10) ? LAT_NOM : lat;
    check("a5.latency", 32'(got_lat), 32'(LAT_NOM));
    pulse_clr();
    check_all("a5.clr");

    // Back-to-back, zero idle, one at the slow baud edge
    send_frame(8'h00, 1'b1, B, 1'b0);
    check_all("b2b.00");
    send_frame(8'hFF, 1'b1, B + 1, 1'b1);
    check_all("b2b.ff");
    send_frame(8'h55, 1'b1, B, 1'b1);
    check_all("b2b.55");
    pulse_clr();

    // Overrun
    idle(B);
    send_frame(8'h12, 1'b1, B, 1'b0);
    send_frame(8'h34, 1'b1, B, 1'b0);
    check_all("ovr");
    pulse_clr();
    check_all("ovr.clr");

    // Framing error with break, then recovery
    send_frame(8'hC3, 1'b0, B, 1'b0);
    repeat (3 * B) @(negedge clk);
    check_all("frm");
    idle(B);
    send_frame(8'h7E, 1'b1, B, 1'b0);
    check_all("frm.7e");
    pulse_clr();
    check_all("frm.clr");

    // Short low glitch then a valid frame
    RX = 1'b0;
    repeat (H / 2) @(negedge clk);
    idle(2 * B);
    check_all("glitch");
    send_frame(8'h81, 1'b1, B, 1'b0);
    check_all("glitch.81");

    // Reset during bit 4 of a frame (with rdy set beforehand)
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = 1'(i & 1);
      repeat (B) @(negedge clk);
    end
    RX = 1'b0;
    repeat (B / 2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("rst.mid");
    RX = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * B);
    send_frame(8'h3C, 1'b1, B, 1'b0);
    check_all("rst.3c");
    pulse_clr();

    // Randomized frames: data, baud skew, clears, gaps, occasional bad stop
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom);
      per = B + int'($urandom_range(0, 1));
      stp = ($urandom_range(0, 7) != 0);
      clr = 1'($urandom_range(0, 1));
      send_frame(d, stp, per, clr);
      check_all($sformatf("rnd%0d", n));
      if (!stp) idle(B + int'($urandom_range(0, B)));
      else      idle(int'($urandom_range(0, 2)) * B);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
